// File: rtl/tile_cfg_sequencer_if.sv
// tile_cfg_sequencer_if
//   Request channel into the tile configuration sequencer.
//   cfg_valid   : request valid (master -> slave)
//   cfg_ready   : sequencer idle and able to take a request (slave -> master)
//   cfg_tile_id : target tile index
//   cfg_word    : configuration word, bit 0 goes out on the serial line first
interface tile_cfg_sequencer_if #(
  parameter int CFG_WIDTH = 64,
  parameter int TILE_ID_W = 4
);
  logic                 cfg_valid;
  logic                 cfg_ready;
  logic [TILE_ID_W-1:0] cfg_tile_id;
  logic [CFG_WIDTH-1:0] cfg_word;

  modport master (output cfg_valid, cfg_tile_id, cfg_word, input cfg_ready);
  modport slave  (input cfg_valid, cfg_tile_id, cfg_word, output cfg_ready);
endinterface

// File: rtl/tile_cfg_sequencer.sv
// tile_cfg_sequencer
//   Programs one CGRA tile at a time: takes a parallel config word and tile id,
//   raises that tile's program_mode and shifts the word out LSB-first on the
//   shared serial line, one bit per clock, then idles GAP_CYCLES before done.
// Ports:
//   clk, rst            : clock, asynchronous active-low reset
//   cfg                 : request channel (valid/ready, tile id, word)
//   abort               : synchronous abort of the load in progress
//   tile_program_mode   : one-hot program_mode, bit [id] high while shifting
//   tile_cfg_data       : serial config bit, 0 outside of shifting
//   busy                : load in progress (shifting or gap)
//   cfg_done/err/aborted: single-cycle status pulses
module tile_cfg_sequencer #(
  parameter int NUM_TILES  = 16,
  parameter int CFG_WIDTH  = 64,
  parameter int TILE_ID_W  = 4,
  parameter int GAP_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  tile_cfg_sequencer_if.slave   cfg,
  input  logic                  abort,
  output logic [NUM_TILES-1:0]  tile_program_mode,
  output logic                  tile_cfg_data,
  output logic                  busy,
  output logic                  cfg_done,
  output logic                  cfg_err,
  output logic                  cfg_aborted
);
  localparam int CW = (CFG_WIDTH > 1) ? $clog2(CFG_WIDTH) : 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [CW-1:0]        LAST_BIT = CW'(CFG_WIDTH - 1);
  localparam logic [GW-1:0]        LAST_GAP = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  // one extra bit so an id equal to NUM_TILES (or above) is representable
  localparam logic [TILE_ID_W:0]   TILE_LIM = (TILE_ID_W + 1)'(NUM_TILES);
  localparam logic [NUM_TILES-1:0] ONE      = NUM_TILES'(1);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_t;

  state_t               state, state_n;
  logic [CW-1:0]        cnt, cnt_n;
  logic [GW-1:0]        gcnt, gcnt_n;
  logic [CFG_WIDTH-1:0] word_q, word_n;
  logic [NUM_TILES-1:0] pm_n;
  logic                 data_n, busy_n, done_n, err_n, abt_n;

  assign cfg.cfg_ready = (state == S_IDLE);

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    gcnt_n  = gcnt;
    word_n  = word_q;
    pm_n    = tile_program_mode;
    data_n  = 1'b0;
    done_n  = 1'b0;
    err_n   = 1'b0;
    abt_n   = 1'b0;
    case (state)
      S_IDLE: begin
        if (cfg.cfg_valid) begin
          if ({1'b0, cfg.cfg_tile_id} < TILE_LIM) begin
            // bit 0 is driven in the very first cycle after acceptance
            state_n = S_SHIFT;
            word_n  = cfg.cfg_word;
            cnt_n   = '0;
            pm_n    = ONE << cfg.cfg_tile_id;
            data_n  = cfg.cfg_word[0];
          end else begin
            err_n = 1'b1;
          end
        end
      end
      S_SHIFT: begin
        if (abort) begin
          // abort wins even on the last-bit edge
          state_n = S_IDLE;
          pm_n    = '0;
          abt_n   = 1'b1;
        end else if (cnt == LAST_BIT) begin
          pm_n = '0;
          if (GAP_CYCLES == 0) begin
            state_n = S_IDLE;
            done_n  = 1'b1;
          end else begin
            state_n = S_GAP;
            gcnt_n  = '0;
          end
        end else begin
          cnt_n  = cnt + 1'b1;
          data_n = word_q[cnt_n];
        end
      end
      S_GAP: begin
        if (abort) begin
          state_n = S_IDLE;
          abt_n   = 1'b1;
        end else if (gcnt == LAST_GAP) begin
          state_n = S_IDLE;
          done_n  = 1'b1;
        end else begin
          gcnt_n = gcnt + 1'b1;
        end
      end
      default: begin
        state_n = S_IDLE;
        pm_n    = '0;
      end
    endcase
    busy_n = (state_n != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state             <= S_IDLE;
      cnt               <= '0;
      gcnt              <= '0;
      word_q            <= '0;
      tile_program_mode <= '0;
      tile_cfg_data     <= 1'b0;
      busy              <= 1'b0;
      cfg_done          <= 1'b0;
      cfg_err           <= 1'b0;
      cfg_aborted       <= 1'b0;
    end else begin
      state             <= state_n;
      cnt               <= cnt_n;
      gcnt              <= gcnt_n;
      word_q            <= word_n;
      tile_program_mode <= pm_n;
      tile_cfg_data     <= data_n;
      busy              <= busy_n;
      cfg_done          <= done_n;
      cfg_err           <= err_n;
      cfg_aborted       <= abt_n;
    end
  end
endmodule

// File: tb/tb_tile_cfg_sequencer.sv
module tb_tile_cfg_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // main fixture: 16 tiles, 5-bit id so out-of-range ids are reachable, GAP=2
  tile_cfg_sequencer_if #(.CFG_WIDTH(64), .TILE_ID_W(5)) ifc();
  logic        abort = 1'b0;
  logic [15:0] pm;
  logic        data, busy, done, err, aborted;

  tile_cfg_sequencer #(.NUM_TILES(16), .CFG_WIDTH(64), .TILE_ID_W(5), .GAP_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .cfg(ifc), .abort(abort),
    .tile_program_mode(pm), .tile_cfg_data(data), .busy(busy),
    .cfg_done(done), .cfg_err(err), .cfg_aborted(aborted)
  );

  // second fixture: no gap cycles
  tile_cfg_sequencer_if #(.CFG_WIDTH(64), .TILE_ID_W(4)) ifc2();
  logic        abort2 = 1'b0;
  logic [15:0] pm2;
  logic        data2, busy2, done2, err2, aborted2;

  tile_cfg_sequencer #(.NUM_TILES(16), .CFG_WIDTH(64), .TILE_ID_W(4), .GAP_CYCLES(0)) dut2 (
    .clk(clk), .rst(rst), .cfg(ifc2), .abort(abort2),
    .tile_program_mode(pm2), .tile_cfg_data(data2), .busy(busy2),
    .cfg_done(done2), .cfg_err(err2), .cfg_aborted(aborted2)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // kind: 0 done, 1 aborted, 2 err
  typedef struct {
    int          kind;
    int          tile;
    logic [63:0] word;
    int          nbits;
    int          lat;
  } txn_t;
  txn_t sb[$];

  int cyc = 0;
  int acc_cyc = 0;
  always @(posedge clk) begin
    cyc++;
    if (rst && ifc.cfg_valid && ifc.cfg_ready) acc_cyc = cyc;
  end

  // monitor: rebuild each load from the outputs and compare to the scoreboard
  bit          in_win = 0;
  int          win_tile = 99;
  int          n_obs = 0;
  logic [63:0] ow = '0;
  int          viol = 0;
  always @(negedge clk) begin
    if (!rst) begin
      in_win = 0; n_obs = 0; ow = '0; win_tile = 99;
    end else begin
      if (ifc.cfg_ready == busy) viol++;
      if (pm != '0) begin
        if (!$onehot(pm)) viol++;
        if (!in_win) begin
          in_win = 1; n_obs = 0; ow = '0;
          for (int i = 0; i < 16; i++) if (pm[i]) win_tile = i;
        end else if (!pm[win_tile]) viol++;
        if (n_obs < 64) ow[n_obs] = data;
        n_obs++;
      end else if (data !== 1'b0) viol++;
      if ((int'(done) + int'(err) + int'(aborted)) > 1) viol++;
      if (done || err || aborted) begin
        if (sb.size() == 0) chk("unexpected_pulse", 1, 0);
        else begin
          txn_t e;
          e = sb.pop_front();
          chk("kind", err ? 2 : (aborted ? 1 : 0), e.kind);
          chk("tile", win_tile, e.tile);
          chk("nbits", n_obs, e.nbits);
          chk("serial_word", ow, e.word);
          chk("latency", cyc - acc_cyc, e.lat);
          chk("violations", viol, 0);
          viol = 0;
        end
        in_win = 0; n_obs = 0; ow = '0; win_tile = 99;
      end
    end
  end

  // drive a request, wait for acceptance, push the expected outcome;
  // returns on the negedge right after the accept edge
  task automatic send(input int id, input logic [63:0] w, input int kind,
                      input int nb, input int lat, input bit push, output time t_acc);
    bit   ok;
    txn_t t;
    ok = 0;
    t_acc = 0;
    ifc.cfg_valid   = 1'b1;
    ifc.cfg_tile_id = 5'(id);
    ifc.cfg_word    = w;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(posedge clk);
      if (ifc.cfg_ready) begin ok = 1; t_acc = $time; end
    end
    if (!ok) chk("accept_timeout", 0, 1);
    else if (push) begin
      t.kind  = kind;
      t.tile  = (kind == 2) ? 99 : id;
      t.nbits = nb;
      t.lat   = lat;
      t.word  = (kind == 2) ? 64'h0 : ((nb >= 64) ? w : (w & ((64'h1 << nb) - 64'h1)));
      sb.push_back(t);
    end
    @(negedge clk);
    ifc.cfg_valid = 1'b0;
  endtask

  initial begin
    time         ta, tb;
    logic [63:0] w2, ow2;
    logic [15:0] pmor;
    int          lat, nb;
    bit          got, ok;

    ifc.cfg_valid = 0; ifc.cfg_tile_id = '0; ifc.cfg_word = '0;
    ifc2.cfg_valid = 0; ifc2.cfg_tile_id = '0; ifc2.cfg_word = '0;

    // reset state
    #3;
    chk("rst_pm", pm, 0);
    chk("rst_data_busy", {data, busy}, 0);
    chk("rst_pulses", {done, err, aborted}, 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", ifc.cfg_ready, 1);

    // single load
    send(0, 64'h0000_0000_0432_1080, 0, 64, 66, 1, ta);

    // out-of-range id: error pulse, nothing programmed
    send(20, 64'h1234, 2, 0, 0, 1, ta);
    chk("err_ready", ifc.cfg_ready, 1);
    chk("err_pm", pm, 0);
    chk("err_pulse", err, 1);

    // back-to-back with valid held: second accept on the done cycle
    send(3, 64'hFFFF_0000_AAAA_5555, 0, 64, 66, 1, ta);
    send(7, 64'h1, 0, 64, 66, 1, tb);
    chk("b2b_spacing", 64'(tb - ta), 64'd670);

    // abort during bit 20
    send(5, 64'hDEAD_BEEF_0123_4567, 1, 21, 21, 1, ta);
    repeat (20) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_pm_drop", pm, 0);

    // accepted again afterwards
    send(6, 64'hC3C3_5A5A_0F0F_9999, 0, 64, 66, 1, ta);

    // abort on the final bit edge
    send(10, 64'h8000_0000_0000_0001, 1, 64, 64, 1, ta);
    repeat (63) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;

    // abort during the gap
    send(12, 64'h0F0F_F0F0_1111_2222, 1, 64, 65, 1, ta);
    repeat (64) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;

    // abort in IDLE is ignored (stray pulse would hit an empty scoreboard)
    repeat (3) @(negedge clk);
    abort = 1'b1;
    repeat (3) @(negedge clk);
    abort = 1'b0;
    chk("idle_abort_ready", ifc.cfg_ready, 1);

    // GAP_CYCLES=0 fixture: done in the cycle after edge N+64
    w2 = 64'hA5A5_0000_FFFF_1234;
    ifc2.cfg_valid = 1'b1; ifc2.cfg_tile_id = 4'd2; ifc2.cfg_word = w2;
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(posedge clk);
      if (ifc2.cfg_ready) ok = 1;
    end
    chk("g0_accept", ok, 1);
    @(negedge clk);
    ifc2.cfg_valid = 1'b0;
    lat = 0; nb = 0; ow2 = '0; pmor = '0; got = 0;
    for (int i = 0; i < 200; i++) begin
      if (done2) begin got = 1; break; end
      if (pm2 != '0) begin
        if (nb < 64) ow2[nb] = data2;
        nb++;
      end
      pmor = pmor | pm2;
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    chk("g0_done_seen", got, 1);
    chk("g0_latency", lat, 64);
    chk("g0_nbits", nb, 64);
    chk("g0_word", ow2, w2);
    chk("g0_pm", pmor, 16'h0004);
    chk("g0_ready_on_done", ifc2.cfg_ready, 1);
    @(negedge clk);
    chk("g0_done_width", done2, 0);

    // async reset between edges mid-shift (not pushed: never completes)
    send(9, 64'hFFFF_FFFF_FFFF_FFFF, 0, 64, 66, 0, ta);
    repeat (10) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("midrst_pm", pm, 0);
    chk("midrst_data_busy", {data, busy}, 0);
    chk("midrst_pulses", {done, err, aborted}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_ready", ifc.cfg_ready, 1);
    repeat (20) @(negedge clk);

    // drain
    for (int i = 0; i < 300 && sb.size() != 0; i++) @(negedge clk);
    chk("sb_drain", sb.size(), 0);
    chk("viol_final", viol, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/tile_cfg_sequencer.md
Name: tile_cfg_sequencer

Overview:
- Configuration controller for the CGRA tile array.
- Accepts a parallel configuration word plus target tile id over a valid/ready handshake.
- Serialises the word LSB-first onto the shared tile serial-config line, one bit per clock, while asserting the selected tile's program_mode.
- Signals done on completion, or signals error/abort; one tile is programmed at a time.

Parameters:
- NUM_TILES, 16, number of tiles driven; width of the one-hot program_mode bus.
- CFG_WIDTH, 64, configuration bits per tile word.
- TILE_ID_W, 4, width of the tile id field; must satisfy 2**TILE_ID_W >= NUM_TILES.
- GAP_CYCLES, 2, idle cycles after the last bit before done; 0 is legal.

Ports:
- clk  input  1  single clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-low reset.
- cfg_valid  input  1  request valid.
- cfg_ready  output  1  sequencer can accept a request (IDLE only).
- cfg_tile_id  input  TILE_ID_W  target tile.
- cfg_word  input  CFG_WIDTH  configuration word; bit 0 is shifted first.
- abort  input  1  synchronous abort of the current load.
- tile_program_mode  output  NUM_TILES  one-hot per-tile program_mode.
- tile_cfg_data  output  1  serial config bit, broadcast to all tiles' jtag_data_in.
- busy  output  1  high in SHIFT or GAP.
- cfg_done  output  1  one-cycle pulse on successful completion.
- cfg_err  output  1  one-cycle pulse: request carried cfg_tile_id >= NUM_TILES.
- cfg_aborted  output  1  one-cycle pulse: load terminated by abort.

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; all outputs registered.
  - tile_program_mode=0, tile_cfg_data=0, busy=0, cfg_done=0, cfg_err=0, cfg_aborted=0.
  - cfg_ready=1 once reset is released.
  - Reset mid-shift drops program_mode immediately; no pulses are emitted.
- States: IDLE, SHIFT, GAP. cfg_ready=1 only in IDLE.
- IDLE, accept at edge N (cfg_valid & cfg_ready):
  - If cfg_tile_id < NUM_TILES: latch word and id, bit counter=0, go to SHIFT.
  - Otherwise: pulse cfg_err in the cycle after N, stay IDLE, drive no program_mode.
- SHIFT, during the cycle after edge N+k (k=0..CFG_WIDTH-1):
  - tile_cfg_data = word[k]; tile_program_mode has only bit [id] high; busy=1.
- Edge N+CFG_WIDTH:
  - program_mode returns to 0 and tile_cfg_data to 0.
  - If GAP_CYCLES>0, enter GAP for exactly GAP_CYCLES cycles; else go directly to IDLE.
- Completion: cfg_done pulses for one cycle, concurrent with the first IDLE cycle (cfg_ready=1).
  - Done cycle = cycle after edge N+CFG_WIDTH+GAP_CYCLES.
  - Back-to-back requests: the next request may be accepted at the edge ending the done cycle.
- Abort: sampled at each edge in SHIFT or GAP.
  - If high: next state IDLE, program_mode=0, data=0, cfg_aborted pulses one cycle, cfg_done not asserted.
  - abort is ignored in IDLE.
  - abort and the final bit edge coinciding: abort wins; aborted pulses, done does not.
- cfg_word and cfg_tile_id are don't-care except at the accept edge; latched values are stable during SHIFT.
- tile_cfg_data is 0 whenever not in SHIFT.
- Bit counter width is $clog2(CFG_WIDTH); the counter does not wrap within a load.
- Invariant: at most one tile_program_mode bit is high in any cycle.

Test Plan:
- Single load: reset, request id=0, word=64'h0000_0000_0432_1080 (matches the 64-cycle serial pattern used by tile_2 benches) -> program_mode[0] high exactly 64 cycles; serial bits equal the word LSB-first; cfg_done at cycle 66 after accept (GAP=2).
- Invalid id: NUM_TILES=16 fixture with TILE_ID_W=5, id=20 -> cfg_err pulse next cycle; program_mode stays 0; cfg_ready remains 1.
- Back-to-back: id=3 word=64'hFFFF_0000_AAAA_5555, then id=7 word=64'h1 with cfg_valid held -> second accept on the done cycle; program_mode[3] then [7] are never overlapping and each is 64 cycles long.
- Abort: abort at bit 20 of a load to id=5 -> program_mode[5] drops next cycle; cfg_aborted pulses once; no cfg_done; a new request is accepted afterwards.
- Abort at final edge (k=63) -> cfg_aborted, no cfg_done; with GAP_CYCLES=0 build, done appears at cycle 64 when not aborted.
- Async reset asserted mid-SHIFT (between edges) -> all outputs 0 immediately; after release, cfg_ready=1 and no stray done/err pulses.
